// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS control unit: FSM state
// encodings, opcode/funct constants, ALUOp codes and ALU control codes.
package multicycle_control_pkg;

  // FSM states; the numeric values are visible on the debug state port.
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  // Opcodes (instr[31:26]).
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (instr[5:0]).
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // ALUOp: internal link between the FSM output decode and the ALU decoder.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_e;

  // ALUControl codes driven to the datapath ALU.
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Moore output bundle produced by the state decode.
  typedef struct packed {
    logic       iord;
    logic       ir_write;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic       pc_write;
    logic       branch;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    aluop_e     alu_op;
  } ctrl_t;

  // True for every opcode the FSM knows how to execute.
  function automatic logic is_supported_op(input logic [5:0] op);
    return (op == OP_LW)   || (op == OP_SW)   || (op == OP_RTYPE) ||
           (op == OP_BEQ)  || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational ALUOp/funct to ALUControl decoder. funct only matters when
// ALUOp selects R-type decoding, which happens only in EXECUTE.
module alu_decoder
  import multicycle_control_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control
);

  // Map ALUOp (and funct for R-type) onto the ALU operation code.
  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    alu_control = ALU_ADD;
    case (aluop_e'(alu_op))
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alu_control = ALU_ADD;
          FUNCT_SUB: alu_control = ALU_SUB;
          FUNCT_AND: alu_control = ALU_AND;
          FUNCT_OR:  alu_control = ALU_OR;
          FUNCT_SLT: alu_control = ALU_SLT;
          default:   alu_control = ALU_ADD;
        endcase
      end
      ALUOP_RSVD: alu_control = ALU_ADD;
      default:    alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: Moore FSM sequencing lw/sw/R-type/beq/addi/j,
// with a registered pulse flagging unsupported opcodes. Branch is exported
// raw; the PC enable is formed downstream together with the ALU Zero flag.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       PCWrite,
  output logic       Branch,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUControl,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_e     state_q, state_d;
  logic       illegal_op_q, illegal_op_d;
  ctrl_t      ctrl;
  logic       state_known;
  logic [2:0] alu_control_raw;

  // State and illegal-op registers; reset returns to FETCH immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      illegal_op_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q      <= state_d;
      illegal_op_q <= illegal_op_d;
    end
  end

  // Next-state logic; op is consulted only in DECODE and MEMADR.
  always_comb begin
    state_d      = S_FETCH;
    illegal_op_d = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
        illegal_op_d = !is_supported_op(op);
      end
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP:
                 state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  // Moore output decode from the current state only; unlisted outputs stay 0.
  always_comb begin
    ctrl        = '0;
    state_known = 1'b1;
    case (state_q)
      S_FETCH: begin
        ctrl.alu_src_b = 2'b01;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
      end
      S_DECODE: ctrl.alu_src_b = 2'b11;
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
      end
      S_MEMRD: ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = 2'b01;
        ctrl.branch    = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_JUMP: begin
        ctrl.pc_src   = 2'b10;
        ctrl.pc_write = 1'b1;
      end
      default: state_known = 1'b0;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (ctrl.alu_op),
    .funct       (funct),
    .alu_control (alu_control_raw)
  );

  // Unreachable encodings force every output, including ALUControl, to 0.
  assign ALUControl = state_known ? alu_control_raw : 3'b000;
  assign IorD       = ctrl.iord;
  assign IRWrite    = ctrl.ir_write;
  assign MemWrite   = ctrl.mem_write;
  assign RegDst     = ctrl.reg_dst;
  assign MemtoReg   = ctrl.mem_to_reg;
  assign RegWrite   = ctrl.reg_write;
  assign ALUSrcA    = ctrl.alu_src_a;
  assign PCWrite    = ctrl.pc_write;
  assign Branch     = ctrl.branch;
  assign ALUSrcB    = ctrl.alu_src_b;
  assign PCSrc      = ctrl.pc_src;
  assign illegal_op = illegal_op_q;
  assign state      = state_q;

endmodule
